// File: rtl/cam_pkg.sv
// Shared definitions for the OV7670-style pixel transmitter and capture path.
//   - state encoding for the frame timing FSM
//   - RGB444 field layout and byte-packing helpers
//   - default OV7670 VGA timing constants
package cam_pkg;

  // Frame timing state encoding
  localparam int unsigned ST_W = 3;
  typedef logic [ST_W-1:0] cam_state_t;
  localparam cam_state_t ST_IDLE   = 3'd0;
  localparam cam_state_t ST_VSYNC  = 3'd1;
  localparam cam_state_t ST_VBP    = 3'd2;
  localparam cam_state_t ST_ACTIVE = 3'd3;
  localparam cam_state_t ST_VFP    = 3'd4;

  // RGB444 pixel layout {R,G,B}
  localparam int unsigned PIX_W  = 12;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CH_W   = 4;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb444_t;

  // First byte on the bus carries red in the low nibble
  function automatic logic [BYTE_W-1:0] rgb_hi_byte(input rgb444_t p);
    return {4'h0, p.r};
  endfunction

  // Second byte carries green/blue
  function automatic logic [BYTE_W-1:0] rgb_lo_byte(input rgb444_t p);
    return {p.g, p.b};
  endfunction

  // Default VGA timing in byte clocks / lines
  localparam int unsigned DEF_H_ACTIVE    = 640;
  localparam int unsigned DEF_V_ACTIVE    = 480;
  localparam int unsigned DEF_H_BLANK     = 288;
  localparam int unsigned DEF_VSYNC_LINES = 3;
  localparam int unsigned DEF_VBP_LINES   = 17;
  localparam int unsigned DEF_VFP_LINES   = 10;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cam_pix_tx_timing.sv
// Frame timing generator for the OV7670-style bus.
// Ports:
//   clk_i, rst_ni  - byte clock, async active-low reset
//   start_i        - frame request, sampled in IDLE
//   state_nxt_o    - state of the slot driven on the next clock
//   act_nxt_o      - next slot is an HREF-high byte
//   phase_nxt_o    - byte phase of the next slot (0 = first byte of pixel)
//   frame_end_o    - current cycle is the last cycle of the frame
// Outputs describe the *next* slot so that a consumer can register its
// pins in step with the counters.
module cam_pix_tx_timing
  import cam_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
  parameter int unsigned H_BLANK     = DEF_H_BLANK,
  parameter int unsigned VSYNC_LINES = DEF_VSYNC_LINES,
  parameter int unsigned VBP_LINES   = DEF_VBP_LINES,
  parameter int unsigned VFP_LINES   = DEF_VFP_LINES
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  output cam_state_t state_nxt_o,
  output logic       act_nxt_o,
  output logic       phase_nxt_o,
  output logic       frame_end_o
);

  localparam int unsigned LINE_LEN  = 2 * H_ACTIVE + H_BLANK;
  localparam int unsigned ACT_BYTES = 2 * H_ACTIVE;
  localparam int unsigned MAX_LINES =
    max_u(max_u(V_ACTIVE, VSYNC_LINES), max_u(VBP_LINES, VFP_LINES));
  localparam int unsigned BCW = cnt_w(LINE_LEN);
  localparam int unsigned LCW = cnt_w(MAX_LINES);

  cam_state_t     state_q, state_d;
  logic [BCW-1:0] byte_q, byte_d;
  logic [LCW-1:0] line_q, line_d;
  logic           line_end;
  logic           last_line;

  // State and counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      byte_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      line_q  <= line_d;
    end
  end

  // Next state / counter advance
  always_comb begin
    state_d   = state_q;
    byte_d    = '0;
    line_d    = line_q;
    line_end  = (byte_q == BCW'(LINE_LEN - 1));
    last_line = 1'b0;

    case (state_q)
      ST_VSYNC:  last_line = (line_q == LCW'(VSYNC_LINES - 1));
      ST_VBP:    last_line = (line_q == LCW'(VBP_LINES - 1));
      ST_ACTIVE: last_line = (line_q == LCW'(V_ACTIVE - 1));
      ST_VFP:    last_line = (line_q == LCW'(VFP_LINES - 1));
      default:   last_line = 1'b0;
    endcase

    if (state_q == ST_IDLE) begin
      line_d = '0;
      if (start_i) begin
        state_d = ST_VSYNC;
      end
    end else begin
      byte_d = line_end ? '0 : byte_q + BCW'(1);
      if (line_end) begin
        if (last_line) begin
          line_d = '0;
          case (state_q)
            ST_VSYNC:  state_d = ST_VBP;
            ST_VBP:    state_d = ST_ACTIVE;
            ST_ACTIVE: state_d = ST_VFP;
            // After VFP spend one cycle in IDLE (frame_done cycle);
            // i_start is sampled there, so a held start restarts at once.
            default:   state_d = ST_IDLE;
          endcase
        end else begin
          line_d = line_q + LCW'(1);
        end
      end
    end
  end

  // Strobes for the datapath
  always_comb begin
    state_nxt_o = state_d;
    act_nxt_o   = (state_d == ST_ACTIVE) &&
                  ({1'b0, byte_d} < (BCW + 1)'(ACT_BYTES));
    phase_nxt_o = byte_d[0];
    frame_end_o = (state_q == ST_VFP) && line_end && last_line;
  end

endmodule

// File: rtl/cam_pix_tx.sv
// OV7670-style parallel pixel transmitter (camera emulator).
// Takes RGB444 pixels over valid/ready and sends two bytes per pixel with
// VSYNC/HREF framing.
// Ports:
//   i_clk, i_rstn   - byte clock, async active-low reset
//   i_start         - frame request level
//   i_data_valid    - pixel on i_data valid
//   o_data_ready    - combinational; high in the cycle before each first byte
//   i_data          - pixel {R,G,B}
//   o_pix_byte      - camera byte, zero while HREF low
//   o_vsync, o_href - frame/line framing
//   o_frame_done    - one-cycle pulse after the last VFP cycle
//   o_underrun      - one-cycle pulse with the first byte of an empty slot
module cam_pix_tx
  import cam_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
  parameter int unsigned H_BLANK     = DEF_H_BLANK,
  parameter int unsigned VSYNC_LINES = DEF_VSYNC_LINES,
  parameter int unsigned VBP_LINES   = DEF_VBP_LINES,
  parameter int unsigned VFP_LINES   = DEF_VFP_LINES
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  input  logic              i_data_valid,
  output logic              o_data_ready,
  input  logic [PIX_W-1:0]  i_data,
  output logic [BYTE_W-1:0] o_pix_byte,
  output logic              o_vsync,
  output logic              o_href,
  output logic              o_frame_done,
  output logic              o_underrun
);

  cam_state_t state_nxt;
  logic       act_nxt;
  logic       phase_nxt;
  logic       frame_end;
  logic       fetch_c;
  rgb444_t    pix_in;

  logic              vsync_q, vsync_d;
  logic              href_q, href_d;
  logic              done_q, done_d;
  logic              underrun_q, underrun_d;
  logic [BYTE_W-1:0] pix_byte_q, pix_byte_d;
  logic [BYTE_W-1:0] pix_lo_q, pix_lo_d;

  cam_pix_tx_timing #(
    .H_ACTIVE    (H_ACTIVE),
    .V_ACTIVE    (V_ACTIVE),
    .H_BLANK     (H_BLANK),
    .VSYNC_LINES (VSYNC_LINES),
    .VBP_LINES   (VBP_LINES),
    .VFP_LINES   (VFP_LINES)
  ) u_timing (
    .clk_i       (i_clk),
    .rst_ni      (i_rstn),
    .start_i     (i_start),
    .state_nxt_o (state_nxt),
    .act_nxt_o   (act_nxt),
    .phase_nxt_o (phase_nxt),
    .frame_end_o (frame_end)
  );

  // Fetch cycle: the next slot is the first byte of a pixel
  assign fetch_c      = act_nxt && !phase_nxt;
  assign o_data_ready = fetch_c;

  // Next-slot pin values; an empty fetch sends a black pixel
  always_comb begin
    vsync_d    = (state_nxt == ST_VSYNC);
    href_d     = act_nxt;
    done_d     = frame_end;
    underrun_d = fetch_c && !i_data_valid;
    pix_byte_d = '0;
    pix_lo_d   = pix_lo_q;
    pix_in     = i_data_valid ? rgb444_t'(i_data) : '0;

    if (fetch_c) begin
      pix_byte_d = rgb_hi_byte(pix_in);
      pix_lo_d   = rgb_lo_byte(pix_in);
    end else if (act_nxt) begin
      pix_byte_d = pix_lo_q;
    end
  end

  // Output registers
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      vsync_q    <= 1'b0;
      href_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      pix_byte_q <= '0;
      pix_lo_q   <= '0;
    end else begin
      vsync_q    <= vsync_d;
      href_q     <= href_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
      pix_byte_q <= pix_byte_d;
      pix_lo_q   <= pix_lo_d;
    end
  end

  assign o_vsync      = vsync_q;
  assign o_href       = href_q;
  assign o_frame_done = done_q;
  assign o_underrun   = underrun_q;
  assign o_pix_byte   = pix_byte_q;

endmodule

// File: tb/tb_cam_pix_tx.sv
// Self-checking bench for cam_pix_tx on a reduced frame geometry.
module tb_cam_pix_tx;

  localparam int H     = 4;
  localparam int VA    = 2;
  localparam int HB    = 3;
  localparam int VS    = 1;
  localparam int VBP   = 1;
  localparam int VFP   = 1;
  localparam int L     = 2 * H + HB;
  localparam int TOTAL = (VS + VBP + VA + VFP) * L;

  typedef struct packed {
    logic [11:0] pix;
    logic        ur;
  } pend_t;

  logic        clk = 1'b0;
  logic        i_rstn;
  logic        i_start;
  logic        i_data_valid;
  logic        o_data_ready;
  logic [11:0] i_data;
  logic [7:0]  o_pix_byte;
  logic        o_vsync;
  logic        o_href;
  logic        o_frame_done;
  logic        o_underrun;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cam_pix_tx #(
    .H_ACTIVE    (H),
    .V_ACTIVE    (VA),
    .H_BLANK     (HB),
    .VSYNC_LINES (VS),
    .VBP_LINES   (VBP),
    .VFP_LINES   (VFP)
  ) dut (
    .i_clk        (clk),
    .i_rstn       (i_rstn),
    .i_start      (i_start),
    .i_data_valid (i_data_valid),
    .o_data_ready (o_data_ready),
    .i_data       (i_data),
    .o_pix_byte   (o_pix_byte),
    .o_vsync      (o_vsync),
    .o_href       (o_href),
    .o_frame_done (o_frame_done),
    .o_underrun   (o_underrun)
  );

  // Reference framing: k counts cycles from VSYNC rising
  function automatic bit href_at(input int k);
    int line;
    int col;
    if (k < 0 || k >= TOTAL) return 1'b0;
    line = k / L;
    col  = k % L;
    return (line >= VS + VBP) && (line < VS + VBP + VA) && (col < 2 * H);
  endfunction

  // Runs nframes frames from IDLE, comparing every cycle against the model.
  // bad_fetch >= 0 forces valid low on that fetch index of every line.
  // abort_k >= 0 returns at that cycle of the first frame (before checks).
  task automatic drive_frames(input int nframes, input bit hold, input int valid_pct,
                              input bit fixed, input int bad_fetch, input int abort_k);
    pend_t q[$];
    pend_t cur;
    pend_t p;
    int    vs_cnt, href_cnt, ur_cnt, ur_exp;
    bit    e_vs, e_hr, e_rdy, e_done, e_ur;
    logic [7:0]  e_byte;
    logic [11:0] d;
    bit          v;
    cur = '0;
    @(posedge clk); #1;
    i_start = 1'b1;
    i_data_valid = 1'b0;
    for (int f = 0; f < nframes; f++) begin
      vs_cnt = 0; href_cnt = 0; ur_cnt = 0; ur_exp = 0;
      for (int k = 0; k <= TOTAL; k++) begin
        @(posedge clk); #1;
        if (k == abort_k) return;
        e_vs   = (k < VS * L);
        e_hr   = href_at(k);
        e_rdy  = href_at(k + 1) && (((k + 1) % L) % 2 == 0);
        e_done = (k == TOTAL);
        e_ur   = 1'b0;
        e_byte = 8'h00;
        if (e_hr) begin
          if ((k % L) % 2 == 0) begin
            cur = (q.size() > 0) ? q.pop_front() : '0;
            e_byte = {4'h0, cur.pix[11:8]};
            e_ur   = cur.ur;
          end else begin
            e_byte = cur.pix[7:0];
          end
        end
        checks++;
        if (o_vsync !== e_vs) begin
          failures++;
          $display("FAIL vsync f=%0d k=%0d got=%b exp=%b", f, k, o_vsync, e_vs);
        end
        checks++;
        if (o_href !== e_hr) begin
          failures++;
          $display("FAIL href f=%0d k=%0d got=%b exp=%b", f, k, o_href, e_hr);
        end
        checks++;
        if (o_data_ready !== e_rdy) begin
          failures++;
          $display("FAIL ready f=%0d k=%0d got=%b exp=%b", f, k, o_data_ready, e_rdy);
        end
        checks++;
        if (o_frame_done !== e_done) begin
          failures++;
          $display("FAIL frame_done f=%0d k=%0d got=%b exp=%b", f, k, o_frame_done, e_done);
        end
        checks++;
        if (o_pix_byte !== e_byte) begin
          failures++;
          $display("FAIL pix_byte f=%0d k=%0d got=%h exp=%h", f, k, o_pix_byte, e_byte);
        end
        checks++;
        if (o_underrun !== e_ur) begin
          failures++;
          $display("FAIL underrun f=%0d k=%0d got=%b exp=%b", f, k, o_underrun, e_ur);
        end
        if (o_vsync === 1'b1) vs_cnt++;
        if (o_href === 1'b1) href_cnt++;
        if (o_underrun === 1'b1) ur_cnt++;
        // Drive this cycle's inputs
        if (!hold || (f == nframes - 1 && k == TOTAL)) i_start = 1'b0;
        v = ($urandom_range(99) < valid_pct);
        d = fixed ? 12'hABC : 12'($urandom);
        if (e_rdy && bad_fetch >= 0 && (((k + 1) % L) / 2) == bad_fetch) v = 1'b0;
        i_data_valid = v;
        i_data = d;
        if (e_rdy) begin
          p.pix = v ? d : 12'h000;
          p.ur  = !v;
          q.push_back(p);
          if (!v) ur_exp++;
        end
      end
      checks++;
      if (vs_cnt != VS * L) begin
        failures++;
        $display("FAIL vsync_len f=%0d got=%0d exp=%0d", f, vs_cnt, VS * L);
      end
      checks++;
      if (href_cnt != 2 * H * VA) begin
        failures++;
        $display("FAIL href_bytes f=%0d got=%0d exp=%0d", f, href_cnt, 2 * H * VA);
      end
      checks++;
      if (ur_cnt != ur_exp) begin
        failures++;
        $display("FAIL underrun_cnt f=%0d got=%0d exp=%0d", f, ur_cnt, ur_exp);
      end
    end
    // Back in IDLE: nothing moves without i_start
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({o_vsync, o_href, o_data_ready, o_frame_done, o_underrun, o_pix_byte} !== 13'h0) begin
        failures++;
        $display("FAIL idle c=%0d got=%b%b%b%b%b byte=%h exp=all zero", c, o_vsync, o_href,
                 o_data_ready, o_frame_done, o_underrun, o_pix_byte);
      end
      i_data_valid = 1'($urandom_range(1));
      i_data = 12'($urandom);
    end
  endtask

  task automatic test_reset();
    i_rstn = 1'b0; i_start = 1'b0; i_data_valid = 1'b1; i_data = 12'hFFF;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({o_vsync, o_href, o_data_ready, o_frame_done, o_underrun, o_pix_byte} !== 13'h0) begin
      failures++;
      $display("FAIL reset_values got=%b%b%b%b%b byte=%h exp=all zero", o_vsync, o_href,
               o_data_ready, o_frame_done, o_underrun, o_pix_byte);
    end
    i_rstn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({o_vsync, o_href, o_data_ready, o_frame_done} !== 4'h0) begin
        failures++;
        $display("FAIL post_reset_idle c=%0d got=%b%b%b%b exp=0000", c, o_vsync, o_href,
                 o_data_ready, o_frame_done);
      end
    end
  endtask

  task automatic test_small_frame();
    drive_frames(1, 1'b0, 100, 1'b0, -1, -1);
  endtask

  task automatic test_byte_order();
    drive_frames(1, 1'b0, 100, 1'b1, -1, -1);
  endtask

  task automatic test_underrun();
    drive_frames(1, 1'b0, 100, 1'b0, 1, -1);
  endtask

  task automatic test_back_to_back();
    drive_frames(3, 1'b1, 100, 1'b0, -1, -1);
  endtask

  task automatic test_random_throttle();
    drive_frames(3, 1'b1, 55, 1'b0, -1, -1);
  endtask

  task automatic test_mid_reset();
    drive_frames(1, 1'b0, 100, 1'b0, -1, (VS + VBP) * L + 3);
    i_rstn = 1'b0;
    #1;
    checks++;
    if ({o_vsync, o_href, o_data_ready, o_frame_done, o_underrun, o_pix_byte} !== 13'h0) begin
      failures++;
      $display("FAIL async_reset got=%b%b%b%b%b byte=%h exp=all zero", o_vsync, o_href,
               o_data_ready, o_frame_done, o_underrun, o_pix_byte);
    end
    i_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    i_rstn = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({o_vsync, o_href, o_data_ready, o_frame_done, o_underrun, o_pix_byte} !== 13'h0) begin
        failures++;
        $display("FAIL no_restart c=%0d got=%b%b%b%b%b byte=%h exp=all zero", c, o_vsync,
                 o_href, o_data_ready, o_frame_done, o_underrun, o_pix_byte);
      end
      i_data_valid = 1'($urandom_range(1));
      i_data = 12'($urandom);
    end
    drive_frames(1, 1'b0, 80, 1'b0, -1, -1);
  endtask

  initial begin
    test_reset();
    test_small_frame();
    test_byte_order();
    test_underrun();
    test_back_to_back();
    test_random_throttle();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
